// File: rtl/apb_obi_pkg.sv
// Shared types and helpers for the APB completer to OBI manager bridge.
package apb_obi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP,
    ST_DONE
  } bridge_state_e;

  localparam logic [3:0] OBI_BE_ALL = 4'b1111;

  // OBI integrity signals carry the inverse of their companion handshake bit.
  function automatic logic obi_par(input logic v);
    return ~v;
  endfunction

endpackage

// File: rtl/apb_to_obi_bridge.sv
// Converts one APB access into one OBI transaction; only a single OBI
// transaction is ever outstanding, and misaligned APB accesses never reach OBI.
module apb_to_obi_bridge
  import apb_obi_pkg::*;
#(
  parameter logic [31:0]        OBI_BASE_ADDR = 32'h0000_0000,
  parameter int                 OBI_IDW       = 1,
  parameter logic [OBI_IDW-1:0] OBI_AID       = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  // APB completer
  input  logic               APB_PSEL,
  input  logic               APB_PENABLE,
  input  logic               APB_PWRITE,
  input  logic [11:0]        APB_PADDR,
  input  logic [31:0]        APB_PWDATA,
  output logic [31:0]        APB_PRDATA,
  output logic               APB_PREADY,
  output logic               APB_PSLVERR,
  // OBI manager
  output logic               req,
  output logic               reqpar,
  input  logic               gnt,
  input  logic               gntpar,
  output logic [31:0]        addr,
  output logic               we,
  output logic [3:0]         be,
  output logic [31:0]        wdata,
  output logic [OBI_IDW-1:0] aid,
  input  logic               rvalid,
  input  logic               rvalidpar,
  output logic               rready,
  output logic               rreadypar,
  input  logic [31:0]        rdata,
  input  logic               err,
  input  logic [OBI_IDW-1:0] rid
);

  bridge_state_e state_q, state_d;
  logic [31:0]   addr_q,  addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q,    we_d;
  logic          err_q,   err_d;
  logic [31:0]   rdata_q, rdata_d;

  // NOTE: every variable gets its hold value before the case statement, so
  // no path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (APB_PSEL && !APB_PENABLE) begin
          addr_d  = OBI_BASE_ADDR + {20'b0, APB_PADDR};
          wdata_d = APB_PWDATA;
          we_d    = APB_PWRITE;
          rdata_d = '0;
          if (APB_PADDR[1:0] == 2'b00) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (gntpar != obi_par(gnt)) err_d = 1'b1;
        if (gnt) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rvalidpar != obi_par(rvalid)) err_d = 1'b1;
        if (rvalid) begin
          if (!we_q) rdata_d = rdata;
          if (err || (rid != OBI_AID)) err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Flag is still presented this cycle via err_q; the next access starts clean.
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge next-state value regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req       = (state_q == ST_REQ);
  assign reqpar    = obi_par(req);
  assign rready    = (state_q == ST_RSP);
  assign rreadypar = obi_par(rready);
  assign addr      = addr_q;
  assign we        = we_q;
  assign be        = OBI_BE_ALL;
  assign wdata     = wdata_q;
  assign aid       = OBI_AID;

  assign APB_PREADY  = (state_q == ST_DONE);
  assign APB_PSLVERR = APB_PREADY && err_q;
  assign APB_PRDATA  = (APB_PREADY && !err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_apb_to_obi_bridge.sv
// Directed bench: two bridge instances with different base addresses share
// one APB/OBI stimulus; the second exists to observe address wrap-around.
module tb_apb_to_obi_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        gnt, gnt_flip;
  logic        rvalid, rvalid_flip;
  logic [31:0] rdata;
  logic        err;
  logic [0:0]  rid;
  logic        gntpar, rvalidpar;

  logic [31:0] prdata, addr, wdata;
  logic        pready, pslverr, req, reqpar, we, rready, rreadypar;
  logic [3:0]  be;
  logic [0:0]  aid;

  logic [31:0] w_prdata, w_addr, w_wdata;
  logic        w_pready, w_pslverr, w_req, w_reqpar, w_we, w_rready, w_rreadypar;
  logic [3:0]  w_be;
  logic [0:0]  w_aid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign gntpar    = ~gnt ^ gnt_flip;
  assign rvalidpar = ~rvalid ^ rvalid_flip;

  apb_to_obi_bridge #(
    .OBI_BASE_ADDR(32'h0103_0000), .OBI_IDW(1), .OBI_AID(1'b0)
  ) u_dut (
    .clk(clk), .reset_n(reset_n),
    .APB_PSEL(psel), .APB_PENABLE(penable), .APB_PWRITE(pwrite),
    .APB_PADDR(paddr), .APB_PWDATA(pwdata), .APB_PRDATA(prdata),
    .APB_PREADY(pready), .APB_PSLVERR(pslverr),
    .req(req), .reqpar(reqpar), .gnt(gnt), .gntpar(gntpar),
    .addr(addr), .we(we), .be(be), .wdata(wdata), .aid(aid),
    .rvalid(rvalid), .rvalidpar(rvalidpar), .rready(rready), .rreadypar(rreadypar),
    .rdata(rdata), .err(err), .rid(rid)
  );

  apb_to_obi_bridge #(
    .OBI_BASE_ADDR(32'hFFFF_FF00), .OBI_IDW(1), .OBI_AID(1'b0)
  ) u_wrap (
    .clk(clk), .reset_n(reset_n),
    .APB_PSEL(psel), .APB_PENABLE(penable), .APB_PWRITE(pwrite),
    .APB_PADDR(paddr), .APB_PWDATA(pwdata), .APB_PRDATA(w_prdata),
    .APB_PREADY(w_pready), .APB_PSLVERR(w_pslverr),
    .req(w_req), .reqpar(w_reqpar), .gnt(gnt), .gntpar(gntpar),
    .addr(w_addr), .we(w_we), .be(w_be), .wdata(w_wdata), .aid(w_aid),
    .rvalid(rvalid), .rvalidpar(rvalidpar), .rready(w_rready), .rreadypar(w_rreadypar),
    .rdata(rdata), .err(err), .rid(rid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge: outputs settled, inputs safe to change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_setup(input logic [11:0] a, input logic wr, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d;
  endtask

  initial begin
    reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; gnt = 1'b0; gnt_flip = 1'b0;
    rvalid = 1'b0; rvalid_flip = 1'b0; rdata = '0; err = 1'b0; rid = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_req",     {31'b0, req},     32'd0);
    check("rst_reqpar",  {31'b0, reqpar},  32'd1);
    check("rst_rready",  {31'b0, rready},  32'd0);
    check("rst_pready",  {31'b0, pready},  32'd0);
    check("rst_pslverr", {31'b0, pslverr}, 32'd0);
    check("rst_prdata",  prdata,           32'd0);
    check("rst_addr",    addr,             32'd0);
    check("rst_wdata",   wdata,            32'd0);
    check("rst_we",      {31'b0, we},      32'd0);
    check("rst_be",      {28'b0, be},      32'hF);
    check("rst_aid",     {31'b0, aid},     32'd0);
    check("rst_wrap_ctl", {24'b0, w_req, w_reqpar, w_rready, w_rreadypar,
                           w_pready, w_pslverr, w_we, w_aid}, 32'h0000_0050);
    check("rst_wrap_dat", w_prdata | w_addr | w_wdata | {28'b0, ~w_be}, 32'd0);
    reset_n = 1'b1;

    // Stray grant in IDLE must not move the FSM
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    check("idle_gnt_req",    {31'b0, req},    32'd0);
    check("idle_gnt_rready", {31'b0, rready}, 32'd0);

    // Read 0x010: gnt T1, rvalid T2, PREADY T3
    apb_setup(12'h010, 1'b0, 32'h0);
    tick();                                   // T1
    check("rd_req",   {31'b0, req},    32'd1);
    check("rd_reqpar",{31'b0, reqpar}, 32'd0);
    check("rd_addr",  addr,            32'h0103_0010);
    check("rd_we",    {31'b0, we},     32'd0);
    check("rd_pready_t1", {31'b0, pready}, 32'd0);
    penable = 1'b1; gnt = 1'b1;
    tick();                                   // T2
    check("rd_rready", {31'b0, rready},    32'd1);
    check("rd_rrpar",  {31'b0, rreadypar}, 32'd0);
    check("rd_req_t2", {31'b0, req},       32'd0);
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();                                   // T3
    check("rd_pready",  {31'b0, pready},  32'd1);
    check("rd_prdata",  prdata,           32'hDEAD_BEEF);
    check("rd_pslverr", {31'b0, pslverr}, 32'd0);
    check("rd_rready_t3", {31'b0, rready}, 32'd0);
    psel = 1'b0; penable = 1'b0; rvalid = 1'b0;
    tick();                                   // T4
    check("rd_pready_t4", {31'b0, pready}, 32'd0);
    check("rd_prdata_t4", prdata,          32'd0);

    // Write 0x004 with grant stalled three cycles
    apb_setup(12'h004, 1'b1, 32'h1234_5678);
    tick();                                   // T1
    penable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      check("wr_req_stall", {31'b0, req}, 32'd1);
      check("wr_addr_stall", addr,        32'h0103_0004);
      check("wr_wdata_stall", wdata,      32'h1234_5678);
      tick();                                 // T2..T4
    end
    check("wr_req_t4", {31'b0, req}, 32'd1);
    check("wr_we",     {31'b0, we},  32'd1);
    check("wr_addr_t4", addr,        32'h0103_0004);
    gnt = 1'b1;
    tick();                                   // T5
    check("wr_req_t5",    {31'b0, req},    32'd0);
    check("wr_rready_t5", {31'b0, rready}, 32'd1);
    check("wr_pready_t5", {31'b0, pready}, 32'd0);
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'hAAAA_5555;
    tick();                                   // T6
    check("wr_pready",  {31'b0, pready},  32'd1);
    check("wr_pslverr", {31'b0, pslverr}, 32'd0);
    check("wr_prdata",  prdata,           32'd0);
    psel = 1'b0; penable = 1'b0; rvalid = 1'b0;
    tick();

    // Misaligned read: immediate error, no OBI request
    apb_setup(12'h003, 1'b0, 32'h0);
    tick();                                   // T1
    check("mis_req",     {31'b0, req},     32'd0);
    check("mis_pready",  {31'b0, pready},  32'd1);
    check("mis_pslverr", {31'b0, pslverr}, 32'd1);
    check("mis_prdata",  prdata,           32'd0);
    penable = 1'b1;
    tick();                                   // T2
    psel = 1'b0; penable = 1'b0;
    check("mis_req_t2",     {31'b0, req},     32'd0);
    check("mis_pready_t2",  {31'b0, pready},  32'd0);
    check("mis_pslverr_t2", {31'b0, pslverr}, 32'd0);

    // Three error reads: err=1, rid mismatch, bad grant parity
    for (int k = 0; k < 3; k++) begin
      apb_setup(12'h008, 1'b0, 32'h0);
      tick();
      penable = 1'b1; gnt = 1'b1; gnt_flip = (k == 2);
      tick();
      gnt = 1'b0; gnt_flip = 1'b0;
      rvalid = 1'b1; rdata = 32'h1111_1111; err = (k == 0); rid = (k == 1) ? 1'b1 : 1'b0;
      tick();
      check("errrd_pready",  {31'b0, pready},  32'd1);
      check("errrd_pslverr", {31'b0, pslverr}, 32'd1);
      check("errrd_prdata",  prdata,           32'd0);
      psel = 1'b0; penable = 1'b0; rvalid = 1'b0; err = 1'b0; rid = 1'b0;
      tick();
    end

    // Reset during RSP, then late response ignored
    apb_setup(12'h00C, 1'b0, 32'h0);
    tick();
    penable = 1'b1; gnt = 1'b1;
    tick();                                   // RSP
    gnt = 1'b0;
    check("rstrsp_rready_pre", {31'b0, rready}, 32'd1);
    reset_n = 1'b0; psel = 1'b0; penable = 1'b0;
    tick();
    check("rstrsp_req",    {31'b0, req},    32'd0);
    check("rstrsp_rready", {31'b0, rready}, 32'd0);
    check("rstrsp_pready", {31'b0, pready}, 32'd0);
    reset_n = 1'b1; rvalid = 1'b1; rdata = 32'h0BAD_0BAD;
    tick();
    rvalid = 1'b0;
    check("late_rsp_pready", {31'b0, pready}, 32'd0);
    check("late_rsp_rready", {31'b0, rready}, 32'd0);

    // Normal read after reset; PSEL dropped mid-transfer is ignored
    apb_setup(12'h020, 1'b0, 32'h0);
    tick();
    psel = 1'b0; gnt = 1'b1;
    check("post_addr", addr, 32'h0103_0020);
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    tick();
    rvalid = 1'b0;
    check("post_pready",  {31'b0, pready},  32'd1);
    check("post_pslverr", {31'b0, pslverr}, 32'd0);
    check("post_prdata",  prdata,           32'hCAFE_F00D);
    tick();

    // Address wrap: base 0xFFFF_FF00 + 0x200
    apb_setup(12'h200, 1'b0, 32'h0);
    tick();
    check("wrap_req",  {31'b0, w_req}, 32'd1);
    check("wrap_addr", w_addr,         32'h0000_0100);
    check("nowrap_addr", addr,         32'h0103_0200);
    penable = 1'b1; gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h5A5A_A5A5;
    tick();
    check("wrap_pready",  {31'b0, w_pready},  32'd1);
    check("wrap_pslverr", {31'b0, w_pslverr}, 32'd0);
    check("wrap_prdata",  w_prdata,           32'h5A5A_A5A5);
    psel = 1'b0; penable = 1'b0; rvalid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
